// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM states, request mode encoding and width helper for the cache set
package cache_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Request mode is the concatenation {comp, write}.
    localparam logic [1:0] MODE_CMP_WR = 2'b11;
    localparam logic [1:0] MODE_ACC_WR = 2'b01;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/assoc_set_way.sv
// rtl/assoc_set_way.sv - one cache line: tag, valid, dirty and word storage with a combinational tag match
module assoc_set_way
    import cache_pkg::*;
#(
    parameter int WORDS  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16,
    localparam int WORD_W = clog2_min1(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [WORD_W-1:0] word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    input  logic              wr_dirty,
    output logic              match,
    output logic [TAG_W-1:0]  tag,
    output logic              valid,
    output logic              dirty,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag   <= '0;
            valid <= 1'b0;
            dirty <= 1'b0;
        end else if (wr_en) begin
            tag   <= req_tag;
            valid <= wr_valid;
            dirty <= wr_dirty;
        end
    end

    // Data is not cleared on reset, but a write racing a reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[word] <= wr_data;
        end
    end

    assign match   = valid && (tag == req_tag);
    assign rd_data = mem[word];

endmodule

// File: rtl/assoc_set.sv
// rtl/assoc_set.sv - set-associative cache set with request/response FSM; ASSOC_SET_LRU_EN selects true-LRU over round-robin
module assoc_set
    import cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16,
    localparam int WAY_W  = clog2_min1(WAYS),
    localparam int WORD_W = clog2_min1(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              comp,
    input  logic              write,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [WORD_W-1:0] word,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              resp_valid,
    output logic              hit,
    output logic              dirty_out,
    output logic              valid_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic [DATA_W-1:0] data_out,
    output logic [WAY_W-1:0]  way_out
);

    logic [1:0]        state;
    logic [1:0]        mode_q;
    logic [TAG_W-1:0]  tag_q;
    logic [WORD_W-1:0] word_q;
    logic [DATA_W-1:0] data_q;
    logic              vin_q;

    logic [WAYS-1:0]   match, line_valid, line_dirty, wr_en;
    logic [TAG_W-1:0]  line_tag  [WAYS];
    logic [DATA_W-1:0] line_data [WAYS];

    logic              hit_any, inv_any, lookup, is_acc_wr, is_cmp_wr;
    logic [WAY_W-1:0]  hit_way, inv_way, repl_way, sel_way;

    assign lookup    = (state == ST_LOOKUP);
    assign is_acc_wr = (mode_q == MODE_ACC_WR);
    assign is_cmp_wr = (mode_q == MODE_CMP_WR);
    assign req_ready = (state == ST_IDLE);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assoc_set_way #(.WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
            .clk(clk), .rst(rst), .wr_en(wr_en[w]), .req_tag(tag_q), .word(word_q),
            .wr_data(data_q), .wr_valid(is_acc_wr ? vin_q : 1'b1), .wr_dirty(!is_acc_wr),
            .match(match[w]), .tag(line_tag[w]), .valid(line_valid[w]),
            .dirty(line_dirty[w]), .rd_data(line_data[w])
        );
    end

    // Lowest index wins for both the hit way and the first invalid way.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!line_valid[i]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(i);
            end
        end
        sel_way = hit_any ? hit_way : (inv_any ? inv_way : repl_way);
        for (int i = 0; i < WAYS; i++) begin
            wr_en[i] = lookup && (sel_way == WAY_W'(i)) && (is_acc_wr || (is_cmp_wr && hit_any));
        end
    end

`ifdef ASSOC_SET_LRU_EN
    logic [WAY_W-1:0] age [WAYS];
    logic             touch;

    // Compare modes touch only on a hit; access-write always touches.
    assign touch = lookup && (is_acc_wr || (mode_q[1] && hit_any));

    always_comb begin
        repl_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age[i] == WAY_W'(WAYS - 1)) begin
                repl_way = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WAYS; i++) begin
            if (rst) begin
                age[i] <= WAY_W'(i);
            end else if (touch) begin
                if (sel_way == WAY_W'(i)) begin
                    age[i] <= '0;
                end else if (age[i] < age[sel_way]) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end
`else
    logic [WAY_W-1:0] rr_ptr;

    // WAYS is a power of two, so the pointer wraps modulo WAYS on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (lookup && is_acc_wr && !hit_any) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end

    assign repl_way = rr_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= '0;
            tag_q      <= '0;
            word_q     <= '0;
            data_q     <= '0;
            vin_q      <= 1'b0;
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            dirty_out  <= 1'b0;
            valid_out  <= 1'b0;
            tag_out    <= '0;
            data_out   <= '0;
            way_out    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state  <= ST_LOOKUP;
                        mode_q <= {comp, write};
                        tag_q  <= tag_in;
                        word_q <= word;
                        data_q <= data_in;
                        vin_q  <= valid_in;
                    end
                end
                ST_LOOKUP: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    hit        <= hit_any;
                    way_out    <= sel_way;
                    valid_out  <= line_valid[sel_way];
                    dirty_out  <= line_dirty[sel_way];
                    tag_out    <= line_tag[sel_way];
                    data_out   <= line_data[sel_way];
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
